// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary definitions: state encoding, payload layouts, masks.
package pipe_pkg;

    // Handshake stage occupancy states; the encoding equals the entry count.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    // IF/ID: pc + instruction word
    localparam int IF_ID_W        = 64;
    localparam int IF_ID_PC_OFF   = 0;
    localparam int IF_ID_INSN_OFF = 32;

    // EX/MM1: control bits in the low byte, then ALU result and store data
    localparam int EX_MM1_W           = 72;
    localparam int EX_MM1_REG_WEN_OFF = 0;
    localparam int EX_MM1_MM_WE_OFF   = 1;
    localparam int EX_MM1_MM_RE_OFF   = 2;
    localparam int EX_MM1_REG_D_OFF   = 3;
    localparam int EX_MM1_ALU_OFF     = 8;
    localparam int EX_MM1_ST_OFF      = 40;

    // A killed EX/MM1 beat must not touch memory or the register file.
    localparam logic [EX_MM1_W-1:0] EX_MM1_KILL_MASK =
        (72'd1 << EX_MM1_MM_RE_OFF) |
        (72'd1 << EX_MM1_MM_WE_OFF) |
        (72'd1 << EX_MM1_REG_WEN_OFF);

    // On flush only the side-effect bits need clearing; data bits may stay stale.
    localparam logic [EX_MM1_W-1:0] EX_MM1_CLR_MASK = EX_MM1_KILL_MASK;

    // IF/ID carries no side-effect bits; kill leaves it intact.
    localparam logic [IF_ID_W-1:0] IF_ID_KILL_MASK = '0;
    localparam logic [IF_ID_W-1:0] IF_ID_CLR_MASK  = '1;

endpackage

// File: rtl/pipe_stage_hs_sat_counter.sv
// Saturating up-counter used for stall profiling.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    // count up on inc, stick at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            value <= '0;
        else if (inc && (value != '1))
            value <= value + 1'b1;
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline register with optional 2-entry skid, flush/kill masks
// and a saturating stall counter.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int           W         = 32,
    parameter logic [W-1:0] CLR_MASK  = {W{1'b1}},
    parameter logic [W-1:0] KILL_MASK = {W{1'b0}},
    parameter int           SKID_EN   = 1,
    parameter int           CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [1:0]   state, state_nxt;
    logic [W-1:0] main_q, skid_q;
    logic [W-1:0] load_val;
    logic         in_fire, out_fire, stall_inc;

    assign load_val  = in_data & ~(in_kill ? KILL_MASK : {W{1'b0}});
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign stall_inc = out_valid & ~out_ready;
    assign out_data  = main_q;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    // next state; flush overrides everything, including a concurrent accept
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_fire) state_nxt = ONE;
                ONE: begin
                    if (in_fire && !out_ready)
                        state_nxt = (SKID_EN != 0) ? TWO : ONE;
                    else if (out_fire && !in_fire)
                        state_nxt = EMPTY;
                end
                TWO:     if (out_fire) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // outputs decoded from state (encoding equals entry count)
    always_comb begin
        out_valid = (state != EMPTY);
        occupancy = state;
    end

    generate
        if (SKID_EN != 0) begin : g_skid
            logic in_ready_q;
            // ready from a flop: low exactly while both entries are occupied
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    in_ready_q <= 1'b1;
                else
                    in_ready_q <= (state_nxt != TWO);
            end
            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign in_ready = !out_valid | out_ready;
        end
    endgenerate

    // storage: load only on accepted beats; flush clears just the masked bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_q <= main_q & ~CLR_MASK;
            skid_q <= skid_q & ~CLR_MASK;
        end else begin
            case (state)
                EMPTY: if (in_fire) main_q <= load_val;
                ONE: begin
                    if (in_fire) begin
                        if (out_ready || (SKID_EN == 0))
                            main_q <= load_val;
                        else
                            skid_q <= load_val;
                    end
                end
                TWO:     if (out_fire) main_q <= skid_q;
                default: ;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .value (stall_cnt)
    );

endmodule
